i2c_tmp100_target: RTL and testbench

- I2C responder (target) that emulates one TMP100 temperature sensor: pointer register, temperature, config, TLOW and THIGH.
- Answers the SSBCC I2C master at the other end of the bus, in simulation benches and on boards with no physical sensor.
- Temperature value is supplied by the fabric; the SDA pad is driven open-drain by the instantiating level.

---
 rtl/i2c_tmp100_pkg.sv | 34 +++
 rtl/i2c_target_phy.sv | 45 ++++
 rtl/i2c_tmp100_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_tmp100_target.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tmp100_pkg.sv
// Shared types and constants for the TMP100 target emulation.
// Also holds the helper that applies the configured resolution to a raw temperature.
package i2c_tmp100_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RACK_CHK,
      S_SKIP
   } state_t;

   localparam logic [1:0] PTR_TEMP  = 2'b00;
   localparam logic [1:0] PTR_CFG   = 2'b01;
   localparam logic [1:0] PTR_TLOW  = 2'b10;
   localparam logic [1:0] PTR_THIGH = 2'b11;

   localparam logic [15:0] TLOW_RST  = 16'h4B00;
   localparam logic [15:0] THIGH_RST = 16'h5000;
   localparam logic [7:0]  CFG_RST   = 8'h00;

   // res 00 keeps 9 bits, 11 keeps all 12
   function automatic logic [11:0] mask_temp(input logic [11:0] temp, input logic [1:0] res);
      logic [11:0] m;
      m = 12'hFFF << (2'd3 - res);
      return temp & m;
   endfunction

endpackage

// File: rtl/i2c_target_phy.sv
// I2C target front end: SCL/SDA synchronisers, SCL edge strobes, START/STOP strobes.
// Latency: SYNC_STAGES+1 clocks pad-to-strobe; no backpressure (strobes are single-cycle pulses).
module i2c_target_phy #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_pad,
   input  logic sda_pad,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_hist;
   logic                   sda_hist;
   logic                   scl;

   // Reset to the idle-bus level so release of reset never looks like an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad};
         scl_hist <= scl_sync[SYNC_STAGES-1];
         sda_hist <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl      = scl_sync[SYNC_STAGES-1];
   assign sda      = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl & ~scl_hist;
   assign scl_fall = ~scl & scl_hist;
   assign start    = scl & scl_hist & sda_hist & ~sda;
   assign stop     = scl & scl_hist & ~sda_hist & sda;

endmodule

// File: rtl/i2c_tmp100_target.sv
// TMP100 sensor emulation on I2C (pointer/temp/config/TLOW/THIGH); optional o_alert under I2C_TMP100_TARGET_ALERT_EN.
// Latency: SDA drive updates one clock after a detected SCL fall; no backpressure, SCL stretching is never used.
module i2c_tmp100_target
   import i2c_tmp100_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h48,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_scl,
   input  logic        i_sda,
   output logic        o_sda_oe,
   input  logic [11:0] i_temp,
   output logic [7:0]  o_cfg,
   output logic        o_busy
`ifdef I2C_TMP100_TARGET_ALERT_EN
   ,
   output logic        o_alert
`endif
);

   logic [1:0] rst_pipe;
   logic       rst_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_pipe <= 2'b00;
      else          rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_n = rst_pipe[1];

   logic sda, scl_rise, scl_fall, start, stop;

   i2c_target_phy #(.SYNC_STAGES(SYNC_STAGES)) u_phy (
      .clk      (i_clk),
      .rst_n    (rst_n),
      .scl_pad  (i_scl),
      .sda_pad  (i_sda),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   state_t      state, state_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [1:0]  byte_idx, byte_idx_nxt;
   logic [1:0]  ptr, ptr_nxt;
   logic [7:0]  cfg, cfg_nxt;
   logic [15:0] tlow, tlow_nxt;
   logic [15:0] thigh, thigh_nxt;
   logic [7:0]  wmsb, wmsb_nxt;
   logic [15:0] word, word_nxt;
   logic        oe, oe_nxt;
   logic        busy, busy_nxt;

   logic [11:0] temp_m;
   logic [15:0] rd_word;
   logic [7:0]  rd_byte;

   assign temp_m  = mask_temp(i_temp, cfg[6:5]);
   assign rd_byte = byte_idx[0] ? word[7:0] : word[15:8];

   always_comb begin
      rd_word = {temp_m, 4'h0};
      case (ptr)
         PTR_CFG:   rd_word = {cfg, cfg};
         PTR_TLOW:  rd_word = tlow;
         PTR_THIGH: rd_word = thigh;
         default:   rd_word = {temp_m, 4'h0};
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         bit_cnt  <= 4'd0;
         shift    <= 8'h00;
         byte_idx <= 2'd0;
         ptr      <= PTR_TEMP;
         cfg      <= CFG_RST;
         tlow     <= TLOW_RST;
         thigh    <= THIGH_RST;
         wmsb     <= 8'h00;
         word     <= 16'h0000;
         oe       <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shift    <= shift_nxt;
         byte_idx <= byte_idx_nxt;
         ptr      <= ptr_nxt;
         cfg      <= cfg_nxt;
         tlow     <= tlow_nxt;
         thigh    <= thigh_nxt;
         wmsb     <= wmsb_nxt;
         word     <= word_nxt;
         oe       <= oe_nxt;
         busy     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      shift_nxt    = shift;
      byte_idx_nxt = byte_idx;
      ptr_nxt      = ptr;
      cfg_nxt      = cfg;
      tlow_nxt     = tlow;
      thigh_nxt    = thigh;
      wmsb_nxt     = wmsb;
      word_nxt     = word;
      oe_nxt       = oe;
      busy_nxt     = busy;

      if (stop) begin
         state_nxt = S_IDLE;
         oe_nxt    = 1'b0;
         busy_nxt  = 1'b0;
      end else if (start) begin
         state_nxt   = S_ADDR;
         bit_cnt_nxt = 4'd0;
      end else if (scl_rise) begin
         case (state)
            S_ADDR, S_PTR, S_WDATA: begin
               if (bit_cnt != 4'd8) begin
                  shift_nxt   = {shift[6:0], sda};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
            S_RDATA: begin
               if (bit_cnt != 4'd8) bit_cnt_nxt = bit_cnt + 4'd1;
            end
            S_RACK_CHK: begin
               if (sda) begin
                  state_nxt = S_SKIP;
                  busy_nxt  = 1'b0;
               end else begin
                  // Next byte's MSB goes out on the coming SCL fall
                  state_nxt    = S_RDATA;
                  bit_cnt_nxt  = 4'd0;
                  byte_idx_nxt = {1'b0, ~byte_idx[0]};
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state)
            S_ADDR: begin
               if (bit_cnt == 4'd8) begin
                  if (shift[7:1] == ADDR) begin
                     state_nxt = S_ADDR_ACK;
                     oe_nxt    = 1'b1;
                     busy_nxt  = 1'b1;
                     if (shift[0]) begin
                        word_nxt     = rd_word;
                        byte_idx_nxt = 2'd0;
                     end
                  end else begin
                     state_nxt = S_SKIP;
                     busy_nxt  = 1'b0;
                  end
               end
            end
            S_ADDR_ACK: begin
               bit_cnt_nxt = 4'd0;
               if (shift[0]) begin
                  state_nxt = S_RDATA;
                  oe_nxt    = ~word[15];
               end else begin
                  state_nxt = S_PTR;
                  oe_nxt    = 1'b0;
               end
            end
            S_PTR: begin
               if (bit_cnt == 4'd8) begin
                  ptr_nxt   = shift[1:0];
                  state_nxt = S_PTR_ACK;
                  oe_nxt    = 1'b1;
               end
            end
            S_PTR_ACK: begin
               state_nxt    = S_WDATA;
               oe_nxt       = 1'b0;
               bit_cnt_nxt  = 4'd0;
               byte_idx_nxt = 2'd0;
            end
            S_WDATA: begin
               if (bit_cnt == 4'd8) begin
                  state_nxt = S_WDATA_ACK;
                  oe_nxt    = 1'b1;
                  case (ptr)
                     PTR_CFG: begin
                        if (byte_idx == 2'd0) cfg_nxt = {1'b0, shift[6:0]};
                     end
                     PTR_TLOW, PTR_THIGH: begin
                        if (byte_idx == 2'd0) begin
                           wmsb_nxt = shift;
                        end else if (byte_idx == 2'd1) begin
                           if (ptr == PTR_TLOW) tlow_nxt  = {wmsb, shift[7:4], 4'h0};
                           else                 thigh_nxt = {wmsb, shift[7:4], 4'h0};
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_WDATA_ACK: begin
               state_nxt   = S_WDATA;
               oe_nxt      = 1'b0;
               bit_cnt_nxt = 4'd0;
               if (byte_idx != 2'd2) byte_idx_nxt = byte_idx + 2'd1;
            end
            S_RDATA: begin
               if (bit_cnt == 4'd8) begin
                  oe_nxt    = 1'b0;
                  state_nxt = S_RACK_CHK;
               end else begin
                  oe_nxt = ~rd_byte[~bit_cnt[2:0]];
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sda_oe = oe;
   assign o_busy   = busy;
   assign o_cfg    = cfg;

`ifdef I2C_TMP100_TARGET_ALERT_EN
   logic alert_act;

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         alert_act <= 1'b0;
      end else if ($signed(temp_m) >= $signed(thigh[15:4])) begin
         alert_act <= 1'b1;
      end else if ($signed(temp_m) < $signed(tlow[15:4])) begin
         alert_act <= 1'b0;
      end
   end

   assign o_alert = cfg[2] ? alert_act : ~alert_act;
`endif

endmodule

// File: tb/tb_i2c_tmp100_target.sv
// Bench for i2c_tmp100_target: bit-banged I2C master, expectations queued by stimulus, popped by a monitor.
module tb_i2c_tmp100_target;

   localparam int Q = 100;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic [11:0] i_temp = 12'h19F;
   logic        o_sda_oe;
   logic [7:0]  o_cfg;
   logic        o_busy;
   logic        sda_line;
`ifdef I2C_TMP100_TARGET_ALERT_EN
   logic        o_alert;
`endif

   assign sda_line = sda_m & ~o_sda_oe;

   always #5 i_clk = ~i_clk;

   i2c_tmp100_target dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_scl    (scl_m),
      .i_sda    (sda_line),
      .o_sda_oe (o_sda_oe),
      .i_temp   (i_temp),
      .o_cfg    (o_cfg),
      .o_busy   (o_busy)
`ifdef I2C_TMP100_TARGET_ALERT_EN
      ,
      .o_alert  (o_alert)
`endif
   );

   typedef struct {
      string       name;
      logic [15:0] val;
   } item_t;

   item_t exp_q[$];
   item_t obs_q[$];
   int    checks = 0;
   int    failures = 0;
   int    oe_cnt = 0;

   always @(posedge i_clk) if (o_sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;

   initial begin
      forever begin
         @(negedge i_clk);
         while (obs_q.size() > 0) begin
            item_t o;
            item_t e;
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL %s: observed %h, no expectation queued", o.name, o.val);
            end else begin
               e = exp_q.pop_front();
               if (o.val !== e.val) begin
                  failures++;
                  $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
               end
            end
         end
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] e, input logic [15:0] a);
      exp_q.push_back('{nm, e});
      obs_q.push_back('{nm, a});
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b = sda_line; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic send_byte(input string nm, input logic [7:0] d, input logic exp_ack);
      logic a;
      exp_q.push_back('{nm, {15'd0, exp_ack}});
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(a);
      obs_q.push_back('{nm, {15'd0, ~a}});
   endtask

   task automatic recv_byte(input string nm, input logic [7:0] expd, input logic ack);
      logic [7:0] d;
      logic       b;
      exp_q.push_back('{nm, {8'd0, expd}});
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(~ack);
      obs_q.push_back('{nm, {8'd0, d}});
   endtask

   task automatic set_ptr(input logic [7:0] p);
      bus_start();
      send_byte("ptr_addr", 8'h90, 1'b1);
      send_byte("ptr_val", p, 1'b1);
      bus_stop();
   endtask

   task automatic wr_cfg(input logic [7:0] v);
      bus_start();
      send_byte("cfg_addr", 8'h90, 1'b1);
      send_byte("cfg_ptr", 8'h01, 1'b1);
      send_byte("cfg_data", v, 1'b1);
      bus_stop();
   endtask

   task automatic rd2(input string nm, input logic [7:0] b0, input logic [7:0] b1);
      bus_start();
      send_byte({nm, "_addr"}, 8'h91, 1'b1);
      recv_byte({nm, "_b0"}, b0, 1'b1);
      recv_byte({nm, "_b1"}, b1, 1'b0);
      bus_stop();
   endtask

   initial begin
      int         cnt0;
      logic       b;
      logic [2:0] pre;

      #100;
      i_rst_n = 1'b1;
      repeat (10) @(posedge i_clk);
      #1;
      chk("rst_oe", 16'd0, {15'd0, o_sda_oe});
      chk("rst_busy", 16'd0, {15'd0, o_busy});
      chk("rst_cfg", 16'h00, {8'd0, o_cfg});

      // Config write then read-back with byte wrap
      bus_start();
      send_byte("w_addr", 8'h90, 1'b1);
      chk("busy_addr", 16'd1, {15'd0, o_busy});
      send_byte("w_ptr", 8'h01, 1'b1);
      send_byte("w_cfg", 8'h60, 1'b1);
      bus_stop();
      #Q;
      chk("cfg_60", 16'h60, {8'd0, o_cfg});
      chk("busy_stop", 16'd0, {15'd0, o_busy});
      rd2("rd_cfg", 8'h60, 8'h60);
      chk("busy_nack", 16'd0, {15'd0, o_busy});

      // Resolution masking with repeated start
      wr_cfg(8'h00);
      bus_start();
      send_byte("sr_addr", 8'h90, 1'b1);
      send_byte("sr_ptr", 8'h00, 1'b1);
      bus_start();
      send_byte("sr_raddr", 8'h91, 1'b1);
      recv_byte("t9_b0", 8'h19, 1'b1);
      recv_byte("t9_b1", 8'h80, 1'b0);
      bus_stop();
      wr_cfg(8'h60);
      set_ptr(8'h00);
      rd2("t12", 8'h19, 8'hF0);

      // Snapshot coherence across a temperature change, then 3-byte wrap
      bus_start();
      send_byte("snap_addr", 8'h91, 1'b1);
      recv_byte("snap_b0", 8'h19, 1'b1);
      i_temp = 12'h2A5;
      recv_byte("snap_b1", 8'hF0, 1'b0);
      bus_stop();
      bus_start();
      send_byte("new_addr", 8'h91, 1'b1);
      recv_byte("new_b0", 8'h2A, 1'b1);
      recv_byte("new_b1", 8'h50, 1'b1);
      recv_byte("new_wrap", 8'h2A, 1'b0);
      bus_stop();

      // Foreign address is ignored
      cnt0 = oe_cnt;
      bus_start();
      send_byte("foreign", 8'h92, 1'b0);
      chk("foreign_busy", 16'd0, {15'd0, o_busy});
      send_byte("foreign_data", 8'h01, 1'b0);
      bus_stop();
      chk("foreign_oe", 16'd0, {15'd0, (oe_cnt != cnt0)});
      chk("foreign_cfg", 16'h60, {8'd0, o_cfg});
      set_ptr(8'h00);

      // OS bit forced low; TLOW/THIGH write rules
      wr_cfg(8'hE0);
      #Q;
      chk("cfg_os", 16'h60, {8'd0, o_cfg});
      bus_start();
      send_byte("tl_addr", 8'h90, 1'b1);
      send_byte("tl_ptr", 8'h02, 1'b1);
      send_byte("tl_msb", 8'h4C, 1'b1);
      send_byte("tl_lsb", 8'h3F, 1'b1);
      bus_start();
      send_byte("tl_raddr", 8'h91, 1'b1);
      recv_byte("tl_b0", 8'h4C, 1'b1);
      recv_byte("tl_b1", 8'h30, 1'b0);
      bus_stop();
      bus_start();
      send_byte("th_addr", 8'h90, 1'b1);
      send_byte("th_ptr", 8'h03, 1'b1);
      send_byte("th_msb_only", 8'h77, 1'b1);
      bus_stop();
      rd2("th_keep", 8'h50, 8'h00);
      bus_start();
      send_byte("th2_addr", 8'h90, 1'b1);
      send_byte("th2_ptr", 8'h03, 1'b1);
      send_byte("th2_msb", 8'h19, 1'b1);
      send_byte("th2_lsb", 8'h00, 1'b1);
      send_byte("th2_extra", 8'hAA, 1'b1);
      bus_stop();
      rd2("th_new", 8'h19, 8'h00);
      bus_start();
      send_byte("tl2_addr", 8'h90, 1'b1);
      send_byte("tl2_ptr", 8'h02, 1'b1);
      send_byte("tl2_msb", 8'h18, 1'b1);
      send_byte("tl2_lsb", 8'h00, 1'b1);
      bus_stop();

`ifdef I2C_TMP100_TARGET_ALERT_EN
      i_temp = 12'h170; repeat (5) @(posedge i_clk); #1;
      chk("alert_170", 16'd1, {15'd0, o_alert});
      i_temp = 12'h1A0; repeat (5) @(posedge i_clk); #1;
      chk("alert_1a0", 16'd0, {15'd0, o_alert});
      i_temp = 12'h185; repeat (5) @(posedge i_clk); #1;
      chk("alert_185", 16'd0, {15'd0, o_alert});
      i_temp = 12'h17F; repeat (5) @(posedge i_clk); #1;
      chk("alert_17f", 16'd1, {15'd0, o_alert});
`endif

      // Reset during the fourth data bit of a temperature read
      i_temp = 12'h2A5;
      set_ptr(8'h00);
      bus_start();
      send_byte("mid_addr", 8'h91, 1'b1);
      for (int i = 2; i >= 0; i--) begin
         get_bit(b);
         pre[i] = b;
      end
      chk("mid_pre3", 16'h0001, {13'd0, pre});
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      chk("mid_oe_before", 16'd1, {15'd0, o_sda_oe});
      chk("mid_busy_before", 16'd1, {15'd0, o_busy});
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_oe", 16'd0, {15'd0, o_sda_oe});
      chk("mid_rst_busy", 16'd0, {15'd0, o_busy});
      chk("mid_rst_cfg", 16'h00, {8'd0, o_cfg});
      #Q;
      i_rst_n = 1'b1;
      repeat (10) @(posedge i_clk);
      rd2("post_rst", 8'h2A, 8'h00);

      for (int i = 0; i < 200 && obs_q.size() > 0; i++) @(negedge i_clk);
      @(negedge i_clk);
      checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations and %0d observations left, required 0 and 0",
                  exp_q.size(), obs_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
